// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU opcodes and multiply-sequencer state encoding for alu_mul_seq.
package alu_mul_seq_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1010,
        ALU_SRA = 4'b1011
    } alu_op_e;

    typedef enum logic [1:0] {
        MUL_ST_IDLE  = 2'd0,
        MUL_ST_ADD   = 2'd1,
        MUL_ST_SHIFT = 2'd2,
        MUL_ST_DONE  = 2'd3
    } mul_st_e;

    localparam logic [3:0] MUL_LAST_BIT = 4'd15;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative 16x16->16 shift-add multiplier that borrows the shared ALU datapath.
// Define MUL_EARLY_EXIT_EN to stop once no multiplier bits remain (variable latency).
module alu_mul_seq
    import alu_mul_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] prod,
    output logic        prod_z,
    output logic        alu_own,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_shd,
    input  logic [15:0] alu_res
);

    mul_st_e     r_state;
    mul_st_e     w_state_nxt;
    logic [15:0] r_mcand;
    logic [15:0] r_mplier;
    logic [15:0] r_acc;
    logic [3:0]  r_cnt;
    logic [15:0] r_prod;
    logic        r_prod_z;

    alu_op_e     w_op;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [3:0]  w_shd;
    logic [3:0]  w_cnt_inc;
    logic [15:0] w_fin;

    always_comb begin
        w_state_nxt = r_state;
        w_op        = ALU_ADD;
        w_a         = '0;
        w_b         = '0;
        w_shd       = '0;
        w_cnt_inc   = r_cnt + 4'd1;
        w_fin       = r_acc;
        case (r_state)
            MUL_ST_IDLE: begin
                w_fin = '0;
                if (start) begin
`ifdef MUL_EARLY_EXIT_EN
                    if (b_in == '0)
                        w_state_nxt = MUL_ST_DONE;
                    else
`endif
                    if (b_in[0])
                        w_state_nxt = MUL_ST_ADD;
                    else
                        w_state_nxt = MUL_ST_SHIFT;
                end
            end
            MUL_ST_ADD: begin
                w_op  = ALU_ADD;
                w_a   = r_mcand;
                w_b   = r_acc;
                w_fin = alu_res;
`ifdef MUL_EARLY_EXIT_EN
                if (r_mplier[15:1] == '0 || r_cnt == MUL_LAST_BIT)
`else
                if (r_cnt == MUL_LAST_BIT)
`endif
                    w_state_nxt = MUL_ST_DONE;
                else
                    w_state_nxt = MUL_ST_SHIFT;
            end
            MUL_ST_SHIFT: begin
                w_op  = ALU_SLL;
                w_b   = r_mcand;
                w_shd = 4'd1;
`ifndef MUL_EARLY_EXIT_EN
                // After the 15th shift a clear top bit means nothing is left to add.
                if (w_cnt_inc == MUL_LAST_BIT && !r_mplier[1])
                    w_state_nxt = MUL_ST_DONE;
                else
`endif
                if (r_mplier[1])
                    w_state_nxt = MUL_ST_ADD;
                else
                    w_state_nxt = MUL_ST_SHIFT;
            end
            MUL_ST_DONE: begin
                w_state_nxt = MUL_ST_IDLE;
            end
            default: w_state_nxt = MUL_ST_IDLE;
        endcase
    end

    // prod is captured on entry to DONE so it is already valid during the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= MUL_ST_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_prod_z <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                MUL_ST_IDLE: begin
                    if (start) begin
                        r_mcand  <= a_in;
                        r_mplier <= b_in;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                MUL_ST_ADD: r_acc <= alu_res;
                MUL_ST_SHIFT: begin
                    r_mcand  <= alu_res;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= w_cnt_inc;
                end
                default: ;
            endcase
            if (w_state_nxt == MUL_ST_DONE && r_state != MUL_ST_DONE) begin
                r_prod   <= w_fin;
                r_prod_z <= (w_fin == '0);
            end
        end
    end

    assign busy    = (r_state != MUL_ST_IDLE);
    assign done    = (r_state == MUL_ST_DONE);
    assign alu_own = (r_state == MUL_ST_ADD) || (r_state == MUL_ST_SHIFT);
    assign alu_op  = w_op;
    assign alu_a   = w_a;
    assign alu_b   = w_b;
    assign alu_shd = w_shd;
    assign prod    = r_prod;
    assign prod_z  = r_prod_z;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq with a behavioural stand-in for the shared ALU.
module tb_alu_mul_seq;
    import alu_mul_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        busy;
    logic        done;
    logic [15:0] prod;
    logic        prod_z;
    logic        alu_own;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_shd;
    logic [15:0] alu_res;

    alu_mul_seq dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .prod(prod), .prod_z(prod_z),
        .alu_own(alu_own), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_shd(alu_shd), .alu_res(alu_res)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            ALU_ADD: alu_res = alu_b + alu_a;
            ALU_SUB: alu_res = alu_b - alu_a;
            ALU_SLL: alu_res = alu_b << alu_shd;
            ALU_SRL: alu_res = alu_b >> alu_shd;
            ALU_SRA: alu_res = $unsigned($signed(alu_b) >>> alu_shd);
            default: alu_res = '0;
        endcase
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] p;
        int unsigned lat;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  opq[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_done = 0;
    logic [15:0] last_prod = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int unsigned exp_lat(input logic [15:0] b);
        int unsigned pc = 0;
        int unsigned msb = 0;
        for (int i = 0; i < 16; i++)
            if (b[i]) begin
                pc++;
                msb = i;
            end
`ifdef MUL_EARLY_EXIT_EN
        return (b == 16'h0) ? 1 : 1 + pc + msb;
`else
        return 16 + pc;
`endif
    endfunction

    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst) begin
            chk("busy", busy, (sb.size() != 0));
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", done, 0);
                end else begin
                    e = sb.pop_front();
                    chk("prod", prod, e.p);
                    chk("prod_z", prod_z, (e.p == 16'h0));
                    chk("latency", cyc - e.acc_cyc + 1, e.lat);
                end
                last_prod = prod;
                n_done++;
            end else begin
                chk("prod_hold", prod, last_prod);
            end
            if (alu_own) opq.push_back(alu_op);
            else chk("idle_drive", {alu_op, alu_a, alu_b, alu_shd}, 40'h0);
        end else begin
            last_prod = '0;
        end
    end

    task automatic wait_idle();
        int unsigned k = 0;
        while ((busy || done) && k < 200) begin
            @(posedge clk); #2;
            k++;
        end
        chk("idle_wait", busy | done, 0);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit hold);
        exp_t x;
        int unsigned k = 0;
        wait_idle();
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        x.a = a;
        x.b = b;
        x.p = a * b;
        x.lat = exp_lat(b);
        x.acc_cyc = cyc + 1;
        sb.push_back(x);
        @(posedge clk); #2;
        if (!hold) start = 1'b0;
        while (!done && k < 100) begin
            @(posedge clk); #2;
            k++;
        end
        chk("done_seen", done, 1);
        start = 1'b0;
    endtask

    logic [3:0] exp_ops[4] = '{ALU_SLL, ALU_ADD, ALU_SLL, ALU_ADD};

    initial begin
        int n0;
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_own", alu_own, 0);
        chk("rst_prod", prod, 0);
        chk("rst_prod_z", prod_z, 1);
        chk("rst_drive", {alu_op, alu_a, alu_b, alu_shd}, 40'h0);
        rst = 1'b0;

        run_op(16'd3, 16'd5, 1'b0);
        run_op(16'h1234, 16'h0000, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0);

        wait_idle();
        opq.delete();
        run_op(16'hFFF9, 16'd6, 1'b0);
        chk("op_count", opq.size(), exp_lat(16'd6) - 1);
`ifdef MUL_EARLY_EXIT_EN
        for (int i = 0; i < 4; i++)
            if (i < opq.size()) chk("op_seq", opq[i], exp_ops[i]);
`endif

        n0 = n_done;
        run_op(16'h0101, 16'h00A3, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        chk("one_done_a", n_done - n0, 1);
        n0 = n_done;
        run_op(16'd7, 16'h8000, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        chk("one_done_b", n_done - n0, 1);

        wait_idle();
        a_in = 16'd3; b_in = 16'd4; start = 1'b1;
        e.a = 16'd3; e.b = 16'd4; e.p = 16'd12; e.lat = exp_lat(16'd4); e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        chk("pre_rst_own", alu_own, 1);
        chk("pre_rst_op", alu_op, ALU_SLL);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_own", alu_own, 0);
        chk("mid_rst_prod", prod, 0);
        chk("mid_rst_prod_z", prod_z, 1);
        chk("mid_rst_done", done, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        run_op(16'd3, 16'd4, 1'b0);

        run_op(16'h4321, 16'h0001, 1'b0);
        for (int i = 0; i < 6; i++)
            run_op(16'($urandom), 16'($urandom), 1'b0);

        wait_idle();
        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
